// File: rtl/pc_gen_pkg.sv
// Shared encodings for the fetch PC generator: PC source select and FSM states.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_SRC_BOOT   = 2'b00,
        PC_SRC_TRAP   = 2'b01,
        PC_SRC_MRET   = 2'b10,
        PC_SRC_NORMAL = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        RST_S  = 2'b00,
        RUN_S  = 2'b01,
        HOLD_S = 2'b10
    } pc_state_e;

    // Byte step used for a 16-bit instruction when compressed fetch is enabled.
    localparam int unsigned PC_C_STEP = 2;

endpackage

// File: rtl/pc_gen_unit_pc_next_sel.sv
// Combinational priority mux for redirect targets: BOOT > TRAP > MRET > branch.
import pc_gen_pkg::*;

module pc_next_sel #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
    input  logic [1:0]       pc_src_in,
    input  logic             branch_taken_in,
    input  logic [XLEN-2:0]  iaddr_in,
    input  logic [XLEN-1:0]  trap_vec_in,
    input  logic [XLEN-1:0]  epc_in,
    output logic [XLEN-1:0]  target_out,
    output logic             redirect_out
);

    always_comb begin
        target_out   = {iaddr_in, 1'b0};
        redirect_out = 1'b0;
        case (pc_src_in)
            PC_SRC_BOOT: begin
                target_out   = RESET_VEC;
                redirect_out = 1'b1;
            end
            PC_SRC_TRAP: begin
                target_out   = trap_vec_in;
                redirect_out = 1'b1;
            end
            PC_SRC_MRET: begin
                target_out   = epc_in;
                redirect_out = 1'b1;
            end
            default: begin
                target_out   = {iaddr_in, 1'b0};
                redirect_out = branch_taken_in;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch PC generator with stall-deferred redirects.
// Optional macro PC_GEN_COMPRESSED_EN enables 2-byte steps for 16-bit instructions.
import pc_gen_pkg::*;

module pc_gen_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
    parameter int unsigned      INC       = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             stall_in,
    input  logic             imem_ready_in,
    input  logic             branch_taken_in,
    input  logic [1:0]       pc_src_in,
    input  logic [XLEN-2:0]  iaddr_in,
    input  logic [XLEN-1:0]  trap_vec_in,
    input  logic [XLEN-1:0]  epc_in,
    input  logic             instr_is_c_in,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_4_out,
    output logic [XLEN-1:0]  i_addr_out,
    output logic             i_req_out,
    output logic             hold_out,
    output logic             misalign_out
);

    pc_state_e        state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [XLEN-1:0]  held_reg, held_next;
    logic             misalign_reg, misalign_next;
    logic             i_req_reg;
    logic             hold_reg;

    logic [XLEN-1:0]  target;
    logic             redirect;
    logic             advance;
    logic [XLEN-1:0]  step;

    pc_next_sel #(
        .XLEN      (XLEN),
        .RESET_VEC (RESET_VEC)
    ) u_next_sel (
        .pc_src_in       (pc_src_in),
        .branch_taken_in (branch_taken_in),
        .iaddr_in        (iaddr_in),
        .trap_vec_in     (trap_vec_in),
        .epc_in          (epc_in),
        .target_out      (target),
        .redirect_out    (redirect)
    );

`ifdef PC_GEN_COMPRESSED_EN
    assign step = instr_is_c_in ? XLEN'(PC_C_STEP) : XLEN'(INC);
`else
    logic unused_instr_is_c;
    assign unused_instr_is_c = instr_is_c_in;
    assign step = XLEN'(INC);
`endif

    assign advance = i_req_reg & imem_ready_in & ~stall_in;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        held_next     = held_reg;
        misalign_next = misalign_reg;
        case (state_reg)
            RST_S: begin
                state_next = RUN_S;
            end
            RUN_S: begin
                if (redirect && !stall_in) begin
                    pc_next       = target;
                    misalign_next = target[1];
                end else if (redirect) begin
                    held_next  = target;
                    state_next = HOLD_S;
                end else if (advance) begin
                    pc_next       = pc_reg + step;
                    misalign_next = 1'b0;
                end
            end
            HOLD_S: begin
                if (stall_in) begin
                    // Newest redirect replaces whatever was latched earlier.
                    if (redirect) begin
                        held_next = target;
                    end
                end else begin
                    pc_next       = redirect ? target : held_reg;
                    misalign_next = redirect ? target[1] : held_reg[1];
                    state_next    = RUN_S;
                end
            end
            default: begin
                state_next = RST_S;
            end
        endcase
`ifdef PC_GEN_COMPRESSED_EN
        misalign_next = 1'b0;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= RST_S;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_reg       <= RESET_VEC;
            held_reg     <= '0;
            misalign_reg <= 1'b0;
            i_req_reg    <= 1'b0;
            hold_reg     <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            held_reg     <= held_next;
            misalign_reg <= misalign_next;
            i_req_reg    <= (state_next != RST_S);
            hold_reg     <= (state_next == HOLD_S);
        end
    end

    assign pc_out        = pc_reg;
    assign pc_plus_4_out = pc_reg + step;
    assign i_req_out     = i_req_reg;
    assign i_addr_out    = i_req_reg ? pc_reg : '0;
    assign hold_out      = hold_reg;
    assign misalign_out  = misalign_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (RESET_VEC = 0x100).
module tb_pc_gen_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RVEC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ready;
    logic        br_taken;
    logic [1:0]  pc_src;
    logic [30:0] iaddr;
    logic [31:0] trap_vec;
    logic [31:0] epc;
    logic        is_c;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic [31:0] i_addr;
    logic        i_req;
    logic        hold;
    logic        misalign;

    int compared;
    int mismatched;

    pc_gen_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .INC       (4)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .stall_in        (stall),
        .imem_ready_in   (ready),
        .branch_taken_in (br_taken),
        .pc_src_in       (pc_src),
        .iaddr_in        (iaddr),
        .trap_vec_in     (trap_vec),
        .epc_in          (epc),
        .instr_is_c_in   (is_c),
        .pc_out          (pc),
        .pc_plus_4_out   (pc_p4),
        .i_addr_out      (i_addr),
        .i_req_out       (i_req),
        .hold_out        (hold),
        .misalign_out    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        ready    = 1'b1;
        br_taken = 1'b0;
        pc_src   = 2'b11;
        iaddr    = '0;
        trap_vec = '0;
        epc      = '0;
        is_c     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        compared++;
        if (pc !== RVEC) begin mismatched++; $display("FAIL reset_pc got=%h exp=%h", pc, RVEC); end
        compared++;
        if (i_req !== 1'b0 || i_addr !== 32'h0) begin mismatched++; $display("FAIL reset_req got=%b/%h exp=0/0", i_req, i_addr); end
        compared++;
        if (hold !== 1'b0 || misalign !== 1'b0) begin mismatched++; $display("FAIL reset_flags got=%b%b exp=00", hold, misalign); end
        rst = 1'b0;
        tick();
        compared++;
        if (i_req !== 1'b1 || i_addr !== RVEC || pc !== RVEC) begin
            mismatched++; $display("FAIL reset_exit got=%b/%h/%h exp=1/%h/%h", i_req, i_addr, pc, RVEC, RVEC);
        end
        $display("test_reset done: pc=%h i_req=%b", pc, i_req);
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = RVEC;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            compared++;
            if (pc !== exp_pc || pc_p4 !== exp_pc + 32'd4 || i_addr !== exp_pc) begin
                mismatched++; $display("FAIL seq%0d got=%h/%h/%h exp=%h/%h/%h", i, pc, pc_p4, i_addr, exp_pc, exp_pc + 32'd4, exp_pc);
            end
            $display("seq step %0d: pc=%h", i, pc);
        end
    endtask

    task automatic test_ready_gating();
        ready = 1'b0;
        tick();
        compared++;
        if (pc !== 32'h10C) begin mismatched++; $display("FAIL not_ready_hold got=%h exp=%h", pc, 32'h10C); end
        // Redirect must not wait for imem_ready.
        br_taken = 1'b1; iaddr = 31'h0000_0090;
        tick();
        compared++;
        if (pc !== 32'h120) begin mismatched++; $display("FAIL redirect_no_ready got=%h exp=%h", pc, 32'h120); end
        br_taken = 1'b0; ready = 1'b1;
        tick();
        compared++;
        if (pc !== 32'h124) begin mismatched++; $display("FAIL after_redirect_seq got=%h exp=%h", pc, 32'h124); end
        $display("test_ready_gating done: pc=%h", pc);
    endtask

    task automatic test_stalled_branch();
        stall = 1'b1; br_taken = 1'b1; iaddr = 31'h0000_0200;
        tick();
        compared++;
        if (hold !== 1'b1 || pc !== 32'h124) begin mismatched++; $display("FAIL stall_br_hold got=%b/%h exp=1/%h", hold, pc, 32'h124); end
        br_taken = 1'b0;
        tick();
        compared++;
        if (hold !== 1'b1 || pc !== 32'h124) begin mismatched++; $display("FAIL stall_br_keep got=%b/%h exp=1/%h", hold, pc, 32'h124); end
        stall = 1'b0;
        tick();
        compared++;
        if (pc !== 32'h400 || hold !== 1'b0 || misalign !== 1'b0) begin
            mismatched++; $display("FAIL stall_br_release got=%h/%b/%b exp=400/0/0", pc, hold, misalign);
        end
        $display("test_stalled_branch done: pc=%h", pc);
    endtask

    task automatic test_priority();
        pc_src = 2'b01; trap_vec = 32'h80; br_taken = 1'b1; iaddr = 31'h0000_0050;
        tick();
        compared++;
        if (pc !== 32'h80) begin mismatched++; $display("FAIL trap_over_branch got=%h exp=80", pc); end
        pc_src = 2'b11; stall = 1'b1;
        tick();
        compared++;
        if (hold !== 1'b1 || pc !== 32'h80) begin mismatched++; $display("FAIL prio_hold got=%b/%h exp=1/80", hold, pc); end
        br_taken = 1'b0; pc_src = 2'b10; epc = 32'h300;
        tick();
        pc_src = 2'b11; stall = 1'b0;
        tick();
        compared++;
        if (pc !== 32'h300 || hold !== 1'b0) begin mismatched++; $display("FAIL mret_overwrite got=%h/%b exp=300/0", pc, hold); end
        pc_src = 2'b00; trap_vec = 32'h44;
        tick();
        compared++;
        if (pc !== RVEC) begin mismatched++; $display("FAIL boot_redirect got=%h exp=%h", pc, RVEC); end
        pc_src = 2'b11;
        $display("test_priority done: pc=%h", pc);
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; iaddr = 31'h7FFF_FFFE;
        tick();
        br_taken = 1'b0;
        compared++;
        if (pc !== 32'hFFFF_FFFC || pc_p4 !== 32'h0) begin mismatched++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/0", pc, pc_p4); end
        tick();
        compared++;
        if (pc !== 32'h0) begin mismatched++; $display("FAIL wrap_zero got=%h exp=0", pc); end
        $display("test_wrap done: pc=%h", pc);
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1; br_taken = 1'b1; iaddr = 31'h0000_0800;
        tick();
        br_taken = 1'b0;
        compared++;
        if (hold !== 1'b1) begin mismatched++; $display("FAIL rst_hold_pre got=%b exp=1", hold); end
        rst = 1'b1;
        tick();
        compared++;
        if (hold !== 1'b0 || pc !== RVEC || i_req !== 1'b0) begin
            mismatched++; $display("FAIL rst_in_hold got=%b/%h/%b exp=0/%h/0", hold, pc, i_req, RVEC);
        end
        rst = 1'b0; stall = 1'b0;
        tick();
        tick();
        compared++;
        if (pc !== RVEC + 32'd4) begin mismatched++; $display("FAIL rst_discard got=%h exp=%h", pc, RVEC + 32'd4); end
        $display("test_reset_in_hold done: pc=%h", pc);
    endtask

    task automatic test_misalign_config();
        br_taken = 1'b1; iaddr = 31'h0000_0081;
        tick();
        br_taken = 1'b0;
        compared++;
        if (pc !== 32'h102) begin mismatched++; $display("FAIL cfg_target got=%h exp=102", pc); end
`ifdef PC_GEN_COMPRESSED_EN
        compared++;
        if (misalign !== 1'b0) begin mismatched++; $display("FAIL cfg_misalign got=%b exp=0", misalign); end
        is_c = 1'b1;
        tick();
        compared++;
        if (pc !== 32'h104) begin mismatched++; $display("FAIL cfg_cstep got=%h exp=104", pc); end
        is_c = 1'b0;
`else
        compared++;
        if (misalign !== 1'b1) begin mismatched++; $display("FAIL cfg_misalign got=%b exp=1", misalign); end
        is_c = 1'b1;
        tick();
        is_c = 1'b0;
        compared++;
        if (pc !== 32'h106 || misalign !== 1'b0) begin mismatched++; $display("FAIL cfg_seq got=%h/%b exp=106/0", pc, misalign); end
`endif
        $display("test_misalign_config done: pc=%h misalign=%b", pc, misalign);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_sequential();
        test_ready_gating();
        test_stalled_branch();
        test_priority();
        test_wrap();
        test_reset_in_hold();
        test_misalign_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
